mod_ser16: RTL and testbench

- Block-to-byte serializer; the read/unload side of the 16-byte AES state register.
- Accepts one 128-bit state as 16 parallel bytes via a valid/ready handshake.
- Streams the bytes out one per transfer, index 0 first, on a byte valid/ready interface. Sits between the cipher datapath and the byte-wide output port.
- Double-buffered: an active buffer plus one pending buffer, so back-to-back blocks stream with no bubble.

---
 rtl/aes_pkg.sv | 16 +
 rtl/mod_ser16_if.sv | 26 ++
 rtl/mod_ser16.sv | 116 +++++++++++
 tb/tb_mod_ser16.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types: byte and 16-byte block containers plus serializer state encoding.
package aes_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned IDX_W       = 4;

  typedef logic [BYTE_W-1:0]        byte_t;
  typedef byte_t [BLOCK_BYTES-1:0]  block_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/mod_ser16_if.sv
// Block-in / byte-out handshake bundle for the AES state unload serializer.
interface mod_ser16_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t i;
  byte_t  o_data;
  logic   o_valid;
  logic   o_ready;
  logic   o_last;
  logic   blk_done;

  // Driver of blocks / consumer of bytes
  modport master (
    output in_valid, i, o_ready,
    input  in_ready, o_data, o_valid, o_last, blk_done
  );

  // Serializer side
  modport slave (
    input  in_valid, i, o_ready,
    output in_ready, o_data, o_valid, o_last, blk_done
  );

endinterface

// File: rtl/mod_ser16.sv
// Double-buffered 16-byte block to byte-stream serializer (active + pending buffer).
module mod_ser16
  import aes_pkg::*;
#(
  parameter int unsigned N = BLOCK_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  mod_ser16_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  block_t           r_act;
  block_t           r_pend;
  logic             r_pend_full;
  logic             r_blk_done;

  logic [0:0]       w_state_nx;
  logic [IDX_W-1:0] w_idx_nx;
  block_t           w_act_nx;
  block_t           w_pend_nx;
  logic             w_pend_full_nx;
  logic             w_blk_done_nx;

  logic w_in_ready;
  logic w_o_valid;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_at_last;

  // Handshake terms come from registers and reset only; no path from in_valid to in_ready
  assign w_in_ready = !reset && !r_pend_full;
  assign w_o_valid  = (r_state == ST_SEND);
  assign w_at_last  = (r_idx == LAST_IDX);
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_out_xfer = w_o_valid && bus.o_ready;

  // State and buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_act       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_blk_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_act       <= w_act_nx;
      r_pend      <= w_pend_nx;
      r_pend_full <= w_pend_full_nx;
      r_blk_done  <= w_blk_done_nx;
    end
  end

  // Next-state: advance index, swap in pending/bypass block at end of block
  always_comb begin
    w_state_nx     = r_state;
    w_idx_nx       = r_idx;
    w_act_nx       = r_act;
    w_pend_nx      = r_pend;
    w_pend_full_nx = r_pend_full;
    w_blk_done_nx  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_in_xfer) begin
          w_act_nx   = bus.i;
          w_idx_nx   = '0;
          w_state_nx = ST_SEND;
        end
      end

      ST_SEND: begin
        if (w_out_xfer && w_at_last) begin
          w_blk_done_nx = 1'b1;
          w_idx_nx      = '0;
          if (r_pend_full) begin
            w_act_nx       = r_pend;
            w_pend_full_nx = 1'b0;
          end else if (w_in_xfer) begin
            w_act_nx = bus.i;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          if (w_out_xfer) begin
            w_idx_nx = r_idx + IDX_W'(1);
          end
          // Bypass case never reaches here, so any accepted block parks in pend
          if (w_in_xfer) begin
            w_pend_nx      = bus.i;
            w_pend_full_nx = 1'b1;
          end
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready = w_in_ready;
  assign bus.o_valid  = w_o_valid;
  assign bus.o_data   = w_o_valid ? r_act[r_idx] : 8'h00;
  assign bus.o_last   = w_o_valid && w_at_last;
  assign bus.blk_done = r_blk_done;

endmodule

// File: tb/tb_mod_ser16.sv
// Directed + random bench for mod_ser16 against a byte-queue reference model.
module tb_mod_ser16;
  import aes_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic clk;
  logic reset;
  mod_ser16_if bus ();

  mod_ser16 #(.N(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic exp_blk_done = 1'b0;
  logic last_accept  = 1'b0;

  function automatic block_t mk(input logic [7:0] base);
    block_t b;
    for (int k = 0; k < 16; k++) b[k] = base + 8'(k);
    return b;
  endfunction

  function automatic block_t rnd_blk();
    block_t b;
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow purely from the queue of bytes still owed downstream
  task automatic check_outputs();
    logic ov;
    logic ir;
    ov = (q.size() > 0);
    ir = !reset && (q.size() <= 16);
    chk("in_ready", 8'(bus.in_ready), 8'(ir));
    chk("o_valid",  8'(bus.o_valid),  8'(ov));
    chk("o_data",   bus.o_data,       ov ? q[0].d : 8'h00);
    chk("o_last",   8'(bus.o_last),   ov ? 8'(q[0].last) : 8'h00);
    chk("blk_done", 8'(bus.blk_done), 8'(exp_blk_done));
  endtask

  // Effect of the coming rising edge on the owed-byte queue
  task automatic model_update();
    logic ir;
    logic popped_last;
    popped_last = 1'b0;
    last_accept = 1'b0;
    if (reset) begin
      q.delete();
      exp_blk_done = 1'b0;
      return;
    end
    ir = (q.size() <= 16);
    if ((q.size() > 0) && bus.o_ready) begin
      popped_last = q[0].last;
      void'(q.pop_front());
    end
    if (bus.in_valid && ir) begin
      last_accept = 1'b1;
      for (int k = 0; k < 16; k++) q.push_back('{d: bus.i[k], last: (k == 15)});
    end
    exp_blk_done = popped_last;
  endtask

  task automatic step(input logic rst, input logic iv, input block_t blk, input logic ordy);
    @(negedge clk);
    check_outputs();
    reset        = rst;
    bus.in_valid = iv;
    bus.i        = blk;
    bus.o_ready  = ordy;
    model_update();
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic   got;
    logic   c_done;
    block_t zero_blk;
    zero_blk     = '0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.i        = '0;
    bus.o_ready  = 1'b0;

    // Reset state, including in_ready held low and valid offered during reset
    #1 check_outputs();
    step(1'b1, 1'b1, mk(8'h55), 1'b1);
    step(1'b1, 1'b0, zero_blk, 1'b1);
    step(1'b0, 1'b0, zero_blk, 1'b1);

    // Single block with downstream always ready
    step(1'b0, 1'b1, mk(8'h10), 1'b1);
    drain(20);

    // Backpressure pattern 1,0,0,1 repeating
    step(1'b0, 1'b1, mk(8'h00), 1'b0);
    for (int n = 0; n < 80; n++) step(1'b0, 1'b0, zero_blk, (n % 4 == 0) || (n % 4 == 3));
    drain(4);

    // Back-to-back: A active, B pending, C held off until A finishes
    step(1'b0, 1'b1, mk(8'hA0), 1'b1);
    step(1'b0, 1'b1, mk(8'hB0), 1'b1);
    c_done = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step(1'b0, !c_done, mk(8'hC0), 1'b1);
      if (last_accept) c_done = 1'b1;
    end
    chk("c_accepted", 8'(c_done), 8'h01);
    drain(4);

    // Bypass: B offered exactly on A's last-byte transfer
    step(1'b0, 1'b1, mk(8'hA0), 1'b1);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      step(1'b0, (q.size() == 1), mk(8'hB0), 1'b1);
      if (last_accept) got = 1'b1;
    end
    chk("bypass_accepted", 8'(got), 8'h01);
    drain(20);

    // Reset mid-stream with pending buffer full
    step(1'b0, 1'b1, mk(8'h30), 1'b1);
    step(1'b0, 1'b1, mk(8'h40), 1'b1);
    for (int n = 0; n < 20 && q.size() > 27; n++) step(1'b0, 1'b0, zero_blk, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    q.delete();
    exp_blk_done = 1'b0;
    check_outputs();
    step(1'b1, 1'b0, zero_blk, 1'b1);
    step(1'b0, 1'b0, zero_blk, 1'b1);
    step(1'b0, 1'b1, mk(8'hC0), 1'b1);
    drain(20);

    // Random traffic
    for (int n = 0; n < 600; n++)
      step(1'b0, 1'($urandom_range(0, 1)), rnd_blk(), ($urandom_range(0, 3) != 0));
    drain(60);
    step(1'b0, 1'b0, zero_blk, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
